// File: rtl/ecc_sram_corrector.sv
// SECDED-protected single-port word store answering bank requests: corrected reads,
// write-back repair of single-bit errors, and read-modify-write for partial byte writes.
module ecc_sram_corrector #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrWidth = $clog2(Depth),
  parameter int unsigned ParWidth  = 7,
  parameter int unsigned EncWidth  = DataWidth + ParWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [AddrWidth-1:0]   add_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   single_error_o,
  output logic                   multi_error_o,
  output logic [AddrWidth-1:0]   err_add_o,
  output logic [15:0]            err_cnt_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned SynWidth = ParWidth - 1;

  typedef enum logic [1:0] {StIdle, StCheck, StRmw} state_e;

  typedef struct packed {
    logic [EncWidth-1:0] fixed;
    logic                single;
    logic                multi;
  } dec_t;

  function automatic logic [EncWidth-1:0] encode(input logic [DataWidth-1:0] d);
    logic [EncWidth-1:0] c;
    logic                par;
    int                  k;
    c = '0;
    k = 0;
    for (int p = 1; p < int'(EncWidth); p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; (1 << b) < int'(EncWidth); b++) begin
      par = 1'b0;
      for (int p = 1; p < int'(EncWidth); p++)
        if (((p & (1 << b)) != 0) && (p != (1 << b))) par ^= c[p];
      c[1 << b] = par;
    end
    c[0] = ^c[EncWidth-1:1];
    return c;
  endfunction

  function automatic logic [DataWidth-1:0] extract(input logic [EncWidth-1:0] c);
    logic [DataWidth-1:0] d;
    int                   k;
    d = '0;
    k = 0;
    for (int p = 1; p < int'(EncWidth); p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return d;
  endfunction

  function automatic dec_t decode(input logic [EncWidth-1:0] c);
    dec_t                r;
    logic [SynWidth-1:0] syn;
    syn = '0;
    for (int p = 1; p < int'(EncWidth); p++)
      if (c[p]) syn ^= p[SynWidth-1:0];
    r.fixed  = c;
    r.single = 1'b0;
    r.multi  = 1'b0;
    if (^c) begin
      // Syndromes beyond the codeword only arise from >2 flips; leave the word alone.
      r.single = 1'b1;
      if (32'(syn) < EncWidth) r.fixed[syn] = ~c[syn];
    end else if (syn != '0) begin
      r.multi = 1'b1;
    end
    return r;
  endfunction

  logic [EncWidth-1:0]  r_mem [Depth];
  logic [EncWidth-1:0]  r_raw;
  state_e               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_add, r_err_add;
  logic [BeWidth-1:0]   r_be;
  logic [DataWidth-1:0] r_wdata, r_rdata;
  logic [15:0]          r_cnt;

  dec_t                 w_dec;
  logic [DataWidth-1:0] w_old_data, w_merged;
  logic                 w_accept, w_rd, w_active, w_inc, w_cap;
  logic                 w_mem_we;
  logic [AddrWidth-1:0] w_mem_add;
  logic [EncWidth-1:0]  w_mem_wcode;

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_dec       = decode(r_raw);
    w_old_data  = extract(w_dec.fixed);
    w_merged    = w_old_data;
    for (int i = 0; i < int'(BeWidth); i++)
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];

    w_active    = (r_state == StCheck) || (r_state == StRmw);
    gnt_o       = (r_state == StIdle) || ((r_state == StCheck) && !w_dec.single);
    w_accept    = req_i && gnt_o;
    w_rd        = w_accept && (!we_i || !(&be_i));
    w_inc       = w_active && w_dec.single;
    w_cap       = w_active && (w_dec.single || w_dec.multi);

    w_state_nxt = StIdle;
    if (w_rd) w_state_nxt = we_i ? StRmw : StCheck;

    // The port is shared: write-back and RMW only happen while gnt_o is low.
    w_mem_we    = 1'b0;
    w_mem_add   = add_i;
    w_mem_wcode = encode(wdata_i);
    if (r_state == StRmw) begin
      w_mem_we    = 1'b1;
      w_mem_add   = r_add;
      w_mem_wcode = encode(w_merged);
    end else if (r_state == StCheck && w_dec.single) begin
      w_mem_we    = 1'b1;
      w_mem_add   = r_add;
      w_mem_wcode = w_dec.fixed;
    end else if (w_accept && we_i && (&be_i)) begin
      w_mem_we    = 1'b1;
    end

    rdata_o        = (r_state == StCheck) ? w_old_data : r_rdata;
    single_error_o = w_active && w_dec.single;
    multi_error_o  = w_active && w_dec.multi;
    err_add_o      = w_cap ? r_add : r_err_add;
    err_cnt_o      = (w_inc && (r_cnt != 16'hFFFF)) ? r_cnt + 16'd1 : r_cnt;
  end

  // NOTE: the array has no reset; its contents are only defined once written.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_add] <= w_mem_wcode;
    if (w_rd)     r_raw <= r_mem[add_i];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_add     <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err_add <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_add <= err_add_o;
      r_cnt     <= err_cnt_o;
      if (r_state == StCheck) r_rdata <= w_old_data;
      if (w_rd) begin
        r_add   <= add_i;
        r_be    <= be_i;
        r_wdata <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ecc_sram_corrector.sv
// Self-checking bench: directed scenarios plus random traffic with backdoor bit flips,
// compared against a word-level model that tracks data and error state per address.
module tb_ecc_sram_corrector;

  localparam int Depth = 256;
  localparam int EncW  = 39;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, gnt;
  logic [3:0]  be;
  logic [7:0]  add;
  logic [31:0] wdata, rdata;
  logic        single_err, multi_err;
  logic [7:0]  err_add;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  ecc_sram_corrector dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .add_i(add), .wdata_i(wdata), .rdata_o(rdata), .single_error_o(single_err),
    .multi_error_o(multi_err), .err_add_o(err_add), .err_cnt_o(err_cnt)
  );

  // Model: per-address data, error kind (0 clean, 1 single, 2 multi, 3 unknown),
  // and the data bits a double flip corrupted.
  logic [31:0] m_data [Depth];
  int          m_kind [Depth];
  logic [31:0] m_flip [Depth];
  int          m_cnt;
  logic [7:0]  m_eadd;
  logic [31:0] l_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data index held at codeword position p, or -1 for parity/overall positions.
  function automatic int dbit(input int p);
    int k = 0;
    if (p == 0 || (p & (p - 1)) == 0) return -1;
    for (int q = 1; q < p; q++) if ((q & (q - 1)) != 0) k++;
    return k;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic void note_error(input int a, input int kind);
    if (kind == 1) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
    if (kind == 1 || kind == 2) m_eadd = a[7:0];
  endfunction

  task automatic flip(input int a, input int p);
    dut.r_mem[a][p] = ~dut.r_mem[a][p];
    if (dbit(p) >= 0) m_flip[a][dbit(p)] = ~m_flip[a][dbit(p)];
  endtask

  task automatic inject(input int a, input int nbits);
    int p0, p1;
    p0 = $urandom_range(0, EncW - 1);
    m_flip[a] = '0;
    flip(a, p0);
    if (nbits == 2) begin
      do p1 = $urandom_range(0, EncW - 1); while (p1 == p0);
      flip(a, p1);
    end
    m_kind[a] = nbits;
  endtask

  task automatic do_read(input int a);
    int          kind = m_kind[a];
    logic [31:0] exp  = (kind == 2) ? (m_data[a] ^ m_flip[a]) : m_data[a];
    req = 1'b1; we = 1'b0; add = a[7:0];
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    l_rdata = rdata;
    if (kind != 3) begin
      note_error(a, kind);
      if (kind == 1) m_kind[a] = 0;
      check("rd_data",   rdata,      exp);
      check("rd_single", single_err, kind == 1);
      check("rd_multi",  multi_err,  kind == 2);
      check("rd_gnt",    gnt,        kind != 1);
      check("rd_cnt",    err_cnt,    m_cnt);
      check("rd_eadd",   err_add,    m_eadd);
    end
    @(negedge clk);
    if (kind != 3) begin
      check("rd_hold",  rdata,                  exp);
      check("rd_flags", {single_err, multi_err}, 2'b00);
    end
  endtask

  task automatic do_write(input int a, input logic [3:0] b, input logic [31:0] d);
    int kind = m_kind[a];
    req = 1'b1; we = 1'b1; be = b; add = a[7:0]; wdata = d;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    if (b == 4'hF) begin
      check("wr_flags", {single_err, multi_err}, 2'b00);
      check("wr_gnt",   gnt, 1'b1);
      m_data[a] = d;
    end else begin
      note_error(a, kind);
      check("rmw_gnt",    gnt,        1'b0);
      check("rmw_single", single_err, kind == 1);
      check("rmw_multi",  multi_err,  kind == 2);
      m_data[a] = merge((kind == 2) ? (m_data[a] ^ m_flip[a]) : m_data[a], d, b);
    end
    m_kind[a] = 0;
    check("wr_cnt",  err_cnt, m_cnt);
    check("wr_eadd", err_add, m_eadd);
    @(negedge clk);
  endtask

  initial begin
    int a, op;
    logic [3:0] b;
    for (int i = 0; i < Depth; i++) begin
      m_kind[i] = 3; m_data[i] = '0; m_flip[i] = '0;
    end
    m_cnt = 0; m_eadd = '0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; add = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {single_err, multi_err}, 2'b00);
    check("rst_eadd",  err_add, 8'h0);
    check("rst_cnt",   err_cnt, 16'h0);
    check("rst_gnt",   gnt, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean write/read, single-error repair, and double-error detection.
    do_write(5, 4'hF, 32'hDEADBEEF);
    do_read(5);
    check("tp1_data", l_rdata, 32'hDEADBEEF);
    flip(5, 10); m_kind[5] = 1;
    do_read(5);
    check("tp2_data", l_rdata, 32'hDEADBEEF);
    check("tp2_cnt",  err_cnt, 16'd1);
    do_read(5);
    do_write(7, 4'hF, 32'h0F0F1234);
    m_flip[7] = '0; flip(7, 3); flip(7, 12); m_kind[7] = 2;
    do_read(7);
    check("tp3_eadd", err_add, 8'd7);
    check("tp3_cnt",  err_cnt, 16'd1);
    do_read(7);

    // Partial write merges bytes via read-modify-write.
    do_write(2, 4'hF, 32'h11223344);
    do_write(2, 4'h3, 32'hAABBCCDD);
    do_read(2);
    check("tp4_data", l_rdata, 32'h1122CCDD);

    // Back-to-back clean reads granted on consecutive cycles.
    do_write(0, 4'hF, 32'hA0A0A0A0);
    do_write(1, 4'hF, 32'hB1B1B1B1);
    req = 1'b1; we = 1'b0; add = 8'd0;
    check("b2b_gnt0", gnt, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("b2b_gnt",   gnt, 1'b1);
      check("b2b_data",  rdata, m_data[i]);
      check("b2b_flags", {single_err, multi_err}, 2'b00);
      add = 8'(i + 1);
      if (i == 2) req = 1'b0;
    end
    @(negedge clk);

    // Highest address behaves like any other.
    do_write(Depth - 1, 4'hF, 32'h87654321);
    do_read(Depth - 1);

    // Random traffic over a small pool of addresses, including the top of the array.
    for (int i = 0; i < 14; i++) begin
      a = (i < 8) ? i : i + 242;
      do_write(a, 4'hF, $urandom);
    end
    for (int n = 0; n < 300; n++) begin
      a  = $urandom_range(0, 13);
      a  = (a < 8) ? a : a + 242;
      op = $urandom_range(0, 9);
      if (m_kind[a] == 3) op = 4;
      if (op <= 3) do_read(a);
      else if (op <= 5) do_write(a, 4'hF, $urandom);
      else if (op <= 7) begin
        b = 4'($urandom_range(1, 14));
        do_write(a, b, $urandom);
      end else if (m_kind[a] == 0) inject(a, op - 7);
      else do_read(a);
    end

    // Reset in the middle of a single-error check abandons the write-back.
    do_write(9, 4'hF, 32'h5A5AA5A5);
    inject(9, 1);
    req = 1'b1; we = 1'b0; add = 8'd9;
    @(posedge clk); @(negedge clk);
    check("mid_single", single_err, 1'b1);
    check("mid_gnt",    gnt, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst2_rdata", rdata, 32'h0);
    check("rst2_flags", {single_err, multi_err}, 2'b00);
    check("rst2_eadd",  err_add, 8'h0);
    check("rst2_cnt",   err_cnt, 16'h0);
    req = 1'b0;
    m_cnt = 0; m_eadd = '0; m_kind[9] = 3;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_gnt", gnt, 1'b1);
    @(negedge clk);
    do_write(9, 4'hF, 32'h13579BDF);
    do_read(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
